// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port word memory between instruction fetch (IF) and load/store (MEM).
// MEM wins by default; a saturating counter caps how many MEM grants in a row may pass over a waiting fetch.
module mem_port_arbiter #(
  parameter int AW       = 10,
  parameter int DW       = 32,
  parameter int MAX_DWIN = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          if_flush,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  output logic          if_stall,
  input  logic          mem_req,
  input  logic          mem_we,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_wdata,
  output logic          mem_ack,
  output logic [DW-1:0] mem_rdata,
  output logic          mem_stall,
  output logic          ram_req,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  input  logic          ram_ack,
  output logic          owner
);

  localparam logic [3:0] C_MAX_DWIN = 4'(MAX_DWIN);

  typedef enum logic [1:0] {IDLE = 2'd0, GNT_I = 2'd1, GNT_D = 2'd2} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [3:0]    r_dcnt;
  logic          r_drop;
  logic          r_ram_we;
  logic [AW-1:0] r_ram_addr;
  logic [DW-1:0] r_ram_wdata;
  logic          r_owner;
  logic          w_if_live;
  logic          w_pick_d;
  logic          w_pick_i;

  assign w_if_live = if_req & ~if_flush;
  assign w_pick_d  = mem_req & (~if_req | if_flush | (r_dcnt < C_MAX_DWIN));
  assign w_pick_i  = ~w_pick_d & w_if_live;

  always_comb begin
    // NOTE: every variable assigned here gets its default first, so no path can infer a latch.
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_pick_d)      w_next = GNT_D;
        else if (w_pick_i) w_next = GNT_I;
      end
      GNT_I, GNT_D: begin
        if (ram_ack) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // Request fields are captured only on the grant edge and then held for the whole access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_owner     <= 1'b0;
    end else if (r_state == IDLE) begin
      if (w_pick_d) begin
        r_ram_we    <= mem_we;
        r_ram_addr  <= mem_addr;
        r_ram_wdata <= mem_wdata;
        r_owner     <= 1'b1;
      end else if (w_pick_i) begin
        r_ram_we    <= 1'b0;
        r_ram_addr  <= if_addr;
        r_owner     <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dcnt <= '0;
    end else if (r_state == IDLE) begin
      if (!if_req || w_pick_i)
        r_dcnt <= '0;
      else if (w_pick_d && !if_flush && (r_dcnt < C_MAX_DWIN))
        r_dcnt <= r_dcnt + 4'd1;
    end
  end

  // A flushed fetch still completes on the RAM side; only its ack is swallowed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                              r_drop <= 1'b0;
    else if (r_state == GNT_I && !ram_ack) r_drop <= r_drop | if_flush;
    else                                   r_drop <= 1'b0;
  end

  assign ram_req   = (r_state != IDLE);
  assign ram_we    = r_ram_we;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;
  assign owner     = r_owner;

  assign if_ack    = (r_state == GNT_I) & ram_ack & ~r_drop & ~if_flush;
  assign mem_ack   = (r_state == GNT_D) & ram_ack;
  assign if_rdata  = if_ack  ? ram_rdata : '0;
  assign mem_rdata = mem_ack ? ram_rdata : '0;
  assign if_stall  = rst & if_req & ~if_ack & ~if_flush;
  assign mem_stall = rst & mem_req & ~mem_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: table-driven single accesses with a response scoreboard,
// plus hand-written sequences for fairness, fetch flush and reset in the middle of an access.
module tb_mem_port_arbiter;
  localparam int AW   = 10;
  localparam int DW   = 32;
  localparam int MAXD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          if_req = 1'b0, if_flush = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_ack, if_stall;
  logic [DW-1:0] if_rdata;
  logic          mem_req = 1'b0, mem_we = 1'b0;
  logic [AW-1:0] mem_addr = '0;
  logic [DW-1:0] mem_wdata = '0;
  logic          mem_ack, mem_stall;
  logic [DW-1:0] mem_rdata;
  logic          ram_req, ram_we, ram_ack = 1'b0, owner;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata = '0;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_DWIN(MAXD)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_ack(if_ack), .if_rdata(if_rdata), .if_stall(if_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_stall(mem_stall),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_ack(ram_ack), .owner(owner)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          is_mem;
    bit          we;
    logic [9:0]  addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    bit          chk;
  } sb_t;

  int   checks = 0;
  int   failures = 0;
  sb_t  sb_if[$];
  sb_t  sb_mem[$];
  bit   grant_q[$];
  int   n_if_ack = 0;
  int   n_mem_ack = 0;
  int   lat_cfg = 0;
  logic [31:0] ram_mem [0:1023];
  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input bit is_mem, input logic [31:0] data, input bit chk);
    sb_t e;
    e.data = data;
    e.chk  = chk;
    if (is_mem) sb_mem.push_back(e);
    else        sb_if.push_back(e);
  endtask

  // RAM model: acks lat_cfg cycles after ram_req rises (latency captured at the start of each access).
  initial begin : ram_model
    int cnt = 0;
    int cur_lat = 0;
    bit started = 0;
    for (int i = 0; i < 1024; i++) ram_mem[i] = 32'hA5A5_0000 | 32'(i);
    ram_mem[10'h010] = 32'h8C01_0004;
    forever begin
      @(negedge clk);
      ram_ack   = 1'b0;
      ram_rdata = '0;
      if (!ram_req) begin
        started = 0;
        cnt     = 0;
      end else begin
        if (!started) begin
          started = 1;
          cur_lat = lat_cfg;
          cnt     = 0;
        end
        if (cnt == cur_lat) begin
          ram_ack = 1'b1;
          if (ram_we) ram_mem[ram_addr] = ram_wdata;
          else        ram_rdata = ram_mem[ram_addr];
          started = 0;
          cnt     = -1000;
        end else begin
          cnt++;
        end
      end
    end
  end

  // Monitor: records grants and pops the scoreboard on every ack.
  initial begin : monitor
    bit  prev_req = 0;
    sb_t e;
    forever begin
      @(negedge clk);
      #1;
      if (ram_req && !prev_req) grant_q.push_back(owner);
      prev_req = ram_req;
      if (if_ack) begin
        n_if_ack++;
        if (sb_if.size() == 0) check("if_ack_unexpected", 64'(sb_if.size()), 1);
        else begin
          e = sb_if.pop_front();
          check("if_rdata", if_rdata, e.data);
        end
      end else if (ram_ack) begin
        check("if_rdata_zero_outside_ack", if_rdata, 0);
      end
      if (mem_ack) begin
        n_mem_ack++;
        if (sb_mem.size() == 0) check("mem_ack_unexpected", 64'(sb_mem.size()), 1);
        else begin
          e = sb_mem.pop_front();
          if (e.chk) check("mem_rdata", mem_rdata, e.data);
        end
      end else if (ram_ack) begin
        check("mem_rdata_zero_outside_ack", mem_rdata, 0);
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Called right after a negedge; returns at negedge+2 of the first cycle with ram_req high.
  task automatic wait_ram_req(input string tag);
    bit ok = 0;
    for (int c = 0; c < 50; c++) begin
      if (c > 0) @(negedge clk);
      #2;
      if (ram_req) begin
        ok = 1;
        break;
      end
    end
    check({tag, "_grant_seen"}, ok, 1);
  endtask

  task automatic do_txn(input vec_t v);
    int stall_cnt = 0;
    int acks = 0;
    bit granted = 0;
    @(negedge clk);
    lat_cfg = v.lat;
    if (v.is_mem) begin
      mem_req = 1'b1; mem_we = v.we; mem_addr = v.addr; mem_wdata = v.wdata;
      push_exp(1'b1, v.exp_rdata, !v.we);
    end else begin
      if_req = 1'b1; if_addr = v.addr;
      push_exp(1'b0, v.exp_rdata, 1'b1);
    end
    for (int c = 0; c < 40 && acks == 0; c++) begin
      if (c > 0) @(negedge clk);
      #2;
      if (v.is_mem ? mem_stall : if_stall) stall_cnt++;
      if (ram_req && !granted) begin
        granted = 1;
        check({v.name, "_ram_we"}, ram_we, v.is_mem & v.we);
        check({v.name, "_owner"}, owner, v.is_mem);
        if (v.is_mem && v.we) check({v.name, "_ram_wdata"}, ram_wdata, v.wdata);
      end
      if (granted) begin
        check({v.name, "_ram_req_held"}, ram_req, 1);
        check({v.name, "_ram_addr"}, ram_addr, v.addr);
      end
      if (v.is_mem ? mem_ack : if_ack) acks++;
    end
    check({v.name, "_ack_count"}, acks, 1);
    check({v.name, "_stall_cycles"}, stall_cnt, v.lat + 1);
    @(negedge clk);
    mem_req = 1'b0;
    if_req  = 1'b0;
    #2;
    check({v.name, "_ack_is_pulse"}, v.is_mem ? mem_ack : if_ack, 0);
    check({v.name, "_ram_req_dropped"}, ram_req, 0);
  endtask

  initial begin : stimulus
    bit exp_order [6];
    int base_g, base_m, base_i;
    bit seen4, seen5, saw_if_ack, done_m, done_i;

    vecs[0] = '{"t2_fetch",      1'b0, 1'b0, 10'h010, 32'h0,         1, 32'h8C01_0004};
    vecs[1] = '{"t3_store",      1'b1, 1'b1, 10'h3FF, 32'hDEAD_BEEF, 0, 32'h0};
    vecs[2] = '{"load_stored",   1'b1, 1'b0, 10'h3FF, 32'h0,         2, 32'hDEAD_BEEF};
    vecs[3] = '{"fetch_stored",  1'b0, 1'b0, 10'h3FF, 32'h0,         0, 32'hDEAD_BEEF};
    vecs[4] = '{"t6_backpress",  1'b1, 1'b0, 10'h005, 32'h0,         5, 32'hA5A5_0005};
    vecs[5] = '{"store_zero",    1'b1, 1'b1, 10'h000, 32'h1234_5678, 3, 32'h0};
    vecs[6] = '{"fetch_zero",    1'b0, 1'b0, 10'h000, 32'h0,         1, 32'h1234_5678};
    vecs[7] = '{"load_2aa",      1'b1, 1'b0, 10'h2AA, 32'h0,         1, 32'hA5A5_02AA};
    exp_order = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    // Reset state, with both requests raised to confirm stalls stay low in reset.
    if_req = 1'b1; mem_req = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    check("rst_ram_req", ram_req, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_wdata", ram_wdata, 0);
    check("rst_owner", owner, 0);
    check("rst_if_stall", if_stall, 0);
    check("rst_mem_stall", mem_stall, 0);
    @(negedge clk);
    if_req = 1'b0; mem_req = 1'b0; rst = 1'b1;

    foreach (vecs[i]) do_txn(vecs[i]);

    // Fairness: both requesters held; expect D,D,D,D,I,D.
    base_g = grant_q.size(); base_m = n_mem_ack; base_i = n_if_ack;
    seen4 = 0; seen5 = 0;
    @(negedge clk);
    lat_cfg = 0;
    if_req = 1'b1; if_addr = 10'h010;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 10'h005;
    for (int k = 0; k < 5; k++) push_exp(1'b1, 32'hA5A5_0005, 1'b1);
    push_exp(1'b0, 32'h8C01_0004, 1'b1);
    for (int c = 0; c < 200; c++) begin
      if (c > 0) @(negedge clk);
      #2;
      if (grant_q.size() - base_g == 4 && !seen4) begin
        seen4 = 1;
        check("t4_dcnt_saturated", dut.r_dcnt, MAXD);
      end
      if (grant_q.size() - base_g == 5 && !seen5) begin
        seen5 = 1;
        check("t4_dcnt_cleared_by_i", dut.r_dcnt, 0);
      end
      if (n_mem_ack - base_m >= 5) break;
    end
    @(negedge clk);
    if_req = 1'b0; mem_req = 1'b0;
    check("t4_mem_acks", n_mem_ack - base_m, 5);
    check("t4_if_acks", n_if_ack - base_i, 1);
    check("t4_grant_count", grant_q.size() - base_g, 6);
    for (int k = 0; k < 6; k++)
      if (base_g + k < grant_q.size())
        check($sformatf("t4_grant%0d", k), grant_q[base_g + k], exp_order[k]);

    // Flush in the 2nd GNT_I cycle with a load waiting; the flushed fetch must never ack.
    @(negedge clk);
    lat_cfg = 4;
    if_req = 1'b1; if_addr = 10'h010;
    wait_ram_req("t5");
    check("t5_owner_i", owner, 0);
    base_i = n_if_ack;
    @(negedge clk);
    if_flush = 1'b1; if_addr = 10'h020;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 10'h005;
    lat_cfg = 1;
    push_exp(1'b1, 32'hA5A5_0005, 1'b1);
    push_exp(1'b0, 32'hA5A5_0020, 1'b1);
    #2;
    check("t5_if_stall_on_flush", if_stall, 0);
    @(negedge clk);
    if_flush = 1'b0;
    saw_if_ack = 0;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) @(negedge clk);
      #2;
      if (if_ack) saw_if_ack = 1;
      if (ram_req && owner) break;
    end
    check("t5_if_ack_suppressed", saw_if_ack, 0);
    check("t5_next_grant_d", owner, 1);
    done_m = 0; done_i = 0;
    for (int c = 0; c < 40 && !(done_m && done_i); c++) begin
      @(negedge clk);
      if (done_m) mem_req = 1'b0;
      #2;
      if (mem_ack) done_m = 1;
      if (if_ack)  done_i = 1;
    end
    @(negedge clk);
    if_req = 1'b0; mem_req = 1'b0;
    check("t5_refetch_acked", n_if_ack - base_i, 1);

    // Reset asserted mid GNT_D with a fetch also waiting.
    @(negedge clk);
    lat_cfg = 10;
    if_req = 1'b1; if_addr = 10'h030;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 10'h100;
    wait_ram_req("t1");
    check("t1_owner_d", owner, 1);
    check("t1_dcnt_before", dut.r_dcnt, 1);
    @(negedge clk);
    rst = 1'b0;
    #2;
    check("t1_ram_req_drop", ram_req, 0);
    check("t1_mem_ack", mem_ack, 0);
    check("t1_mem_stall", mem_stall, 0);
    check("t1_if_stall", if_stall, 0);
    @(negedge clk);
    if_req = 1'b0; mem_req = 1'b0; rst = 1'b1;
    #2;
    check("t1_state_idle", dut.r_state, 0);
    check("t1_dcnt_zero", dut.r_dcnt, 0);
    check("t1_owner_zero", owner, 0);
    check("t1_ram_addr_zero", ram_addr, 0);
    do_txn(vecs[0]);

    repeat (2) @(negedge clk);
    check("sb_if_drained", sb_if.size(), 0);
    check("sb_mem_drained", sb_mem.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
